// File: rtl/bram_log_reader_pkg.sv
// Shared definitions for the event log BRAM: entry geometry, field offsets and the reader FSM states.
// Used by the log reader and by the logger side.
package bram_log_pkg;

  localparam int TIMESTAMP_BITW = 32;
  localparam int TS_LSB         = 0;
  localparam int DATA_LSB       = TIMESTAMP_BITW;

  // Entries are padded up to a whole number of 32-bit words.
  function automatic int entry_bitw(input int log_data_bitw);
    return ((TIMESTAMP_BITW + log_data_bitw + 31) / 32) * 32;
  endfunction

  function automatic int entry_bytew(input int log_data_bitw);
    return entry_bitw(log_data_bitw) / 8;
  endfunction

  function automatic int addr_bitw(input int num_log_entries, input int log_data_bitw);
    return $clog2(num_log_entries) + $clog2(entry_bytew(log_data_bitw));
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/bram_log_reader_if.sv
// Control, BRAM port and output stream signals of the log reader.
// master = the reader, slave = the surrounding system.
interface bram_log_reader_if
  import bram_log_pkg::*;
#(
  parameter int LOG_DATA_BITW   = 32,
  parameter int NUM_LOG_ENTRIES = 16384
) ();

  localparam int ENTRY_BITW = entry_bitw(LOG_DATA_BITW);
  localparam int CNT_BITW   = $clog2(NUM_LOG_ENTRIES);
  localparam int ADDR_BITW  = addr_bitw(NUM_LOG_ENTRIES, LOG_DATA_BITW);

  logic                     Start_SI;
  logic                     Abort_SI;
  logic [CNT_BITW:0]        NumEntries_DI;
  logic                     BramEn_SO;
  logic [ADDR_BITW-1:0]     BramAddr_SO;
  logic [ENTRY_BITW-1:0]    BramRd_DI;
  logic                     Valid_SO;
  logic                     Ready_SI;
  logic [TIMESTAMP_BITW-1:0] Timestamp_DO;
  logic [LOG_DATA_BITW-1:0] LogData_DO;
  logic                     Last_SO;
  logic                     Busy_SO;
  logic                     Done_SO;

  modport master (
    input  Start_SI, Abort_SI, NumEntries_DI, BramRd_DI, Ready_SI,
    output BramEn_SO, BramAddr_SO, Valid_SO, Timestamp_DO, LogData_DO,
           Last_SO, Busy_SO, Done_SO
  );

  modport slave (
    output Start_SI, Abort_SI, NumEntries_DI, BramRd_DI, Ready_SI,
    input  BramEn_SO, BramAddr_SO, Valid_SO, Timestamp_DO, LogData_DO,
           Last_SO, Busy_SO, Done_SO
  );

endinterface

// File: rtl/bram_log_reader_fifo.sv
// Two-entry output buffer for the log reader: registered slots, occupancy count, synchronous flush.
module log_entry_fifo #(
  parameter int WIDTH = 65
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Slots reset to zero so the head reads as all-zero data out of reset.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic [WIDTH-1:0] slot_q, slot_d;

    always_comb begin
      slot_d = slot_q;
      if (push_i && !flush_i && (wr_ptr_q == 1'(gi))) slot_d = data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) slot_q <= '0;
      else         slot_q <= slot_d;
    end
  end

  assign data_o  = rd_ptr_q ? g_slot[1].slot_q : g_slot[0].slot_q;
  assign count_o = count_q;

endmodule

// File: rtl/bram_log_reader.sv
// Drains the event log BRAM from index 0 upward and streams entries over valid/ready.
// Optional BRAM_LOG_READER_STOP_ON_EMPTY_EN: an entry with timestamp 0 ends the drain early.
module bram_log_reader
  import bram_log_pkg::*;
#(
  parameter int LOG_DATA_BITW   = 32,
  parameter int NUM_LOG_ENTRIES = 16384
) (
  input logic               Clk_CI,
  input logic               Rst_RBI,
  bram_log_reader_if.master bus
);

  localparam int ENTRY_BITW  = entry_bitw(LOG_DATA_BITW);
  localparam int ENTRY_BYTEW = entry_bytew(LOG_DATA_BITW);
  localparam int CNT_BITW    = $clog2(NUM_LOG_ENTRIES);
  localparam int OFS_BITW    = $clog2(ENTRY_BYTEW);
  localparam int FIFO_W      = ENTRY_BITW + 1;
  localparam logic [CNT_BITW:0] MAX_CNT = (CNT_BITW + 1)'(NUM_LOG_ENTRIES);
  localparam logic [CNT_BITW:0] ONE     = (CNT_BITW + 1)'(1);

  state_e            state_q, state_d;
  logic [CNT_BITW:0] cnt_q, cnt_d;
  logic [CNT_BITW:0] idx_q, idx_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;

  logic [1:0]        fifo_count;
  logic [FIFO_W-1:0] fifo_head;
  logic [2:0]        occupancy;
  logic              valid, pop, push, flush, issue, done, last_idx, empty_hit;

  assign valid     = (fifo_count != 2'd0);
  assign pop       = valid && bus.Ready_SI;
  assign last_idx  = (idx_q == cnt_q - ONE);
  // Entries buffered after this cycle's pop, plus the read whose data is on the bus now.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

`ifdef BRAM_LOG_READER_STOP_ON_EMPTY_EN
  assign empty_hit = inflight_q && (bus.BramRd_DI[TS_LSB +: TIMESTAMP_BITW] == '0);
`else
  assign empty_hit = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    issue           = 1'b0;
    flush           = 1'b0;
    done            = 1'b0;
    push            = inflight_q && !empty_hit;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start_SI && !bus.Abort_SI) begin
          cnt_d   = (bus.NumEntries_DI > MAX_CNT) ? MAX_CNT : bus.NumEntries_DI;
          idx_d   = '0;
          state_d = (bus.NumEntries_DI == '0) ? ST_FLUSH : ST_READ;
        end
      end
      ST_READ: begin
        if (bus.Abort_SI) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
          push    = 1'b0;
        end else if (empty_hit) begin
          // Cleared entry: no further reads, just let the buffer drain.
          state_d = ST_FLUSH;
        end else if (occupancy < 3'd2) begin
          issue           = 1'b1;
          idx_d           = idx_q + ONE;
          inflight_d      = 1'b1;
          inflight_last_d = last_idx;
          if (last_idx) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (bus.Abort_SI) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
          push    = 1'b0;
        end else if (fifo_count == 2'd0 && !inflight_q) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  log_entry_fifo #(.WIDTH(FIFO_W)) u_fifo (
    .clk_i   (Clk_CI),
    .rst_ni  (Rst_RBI),
    .flush_i (flush),
    .push_i  (push),
    .data_i  ({inflight_last_q, bus.BramRd_DI}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign bus.BramEn_SO    = issue;
  assign bus.BramAddr_SO  = {idx_q[CNT_BITW-1:0], {OFS_BITW{1'b0}}};
  assign bus.Valid_SO     = valid;
  assign bus.Timestamp_DO = fifo_head[TS_LSB +: TIMESTAMP_BITW];
  assign bus.LogData_DO   = fifo_head[DATA_LSB +: LOG_DATA_BITW];
  assign bus.Last_SO      = valid && fifo_head[ENTRY_BITW];
  assign bus.Busy_SO      = (state_q != ST_IDLE);
  assign bus.Done_SO      = done;

endmodule

// File: tb/tb_bram_log_reader.sv
// Randomized bench for bram_log_reader: BRAM model, per-drain expected-entry queue, per-cycle compare.
`timescale 1ns/1ps
module tb_bram_log_reader;
  import bram_log_pkg::*;

  localparam int LDW  = 32;
  localparam int NENT = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_log_reader_if #(.LOG_DATA_BITW(LDW), .NUM_LOG_ENTRIES(NENT)) bus ();

  bram_log_reader #(.LOG_DATA_BITW(LDW), .NUM_LOG_ENTRIES(NENT)) dut (
    .Clk_CI  (clk),
    .Rst_RBI (rst_n),
    .bus     (bus)
  );

  // BRAM model: registered read, one cycle latency
  logic [63:0] mem [NENT];
  logic [63:0] rd_q;
  always @(posedge clk) if (bus.BramEn_SO) rd_q <= mem[bus.BramAddr_SO[12:3]];
  assign bus.BramRd_DI = rd_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Ready driver: 0 hold, 1 always high, 2 one-in-three, 3 random
  int ready_mode = 1;
  int phase = 0;
  initial begin
    bus.Ready_SI = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1: bus.Ready_SI = 1'b1;
        2: begin bus.Ready_SI = (phase == 0); phase = (phase + 1) % 3; end
        3: bus.Ready_SI = ($urandom_range(0, 3) != 0);
        default: ;
      endcase
    end
  end

  typedef struct { logic [31:0] ts; logic [31:0] data; logic last; } exp_t;
  exp_t exp_q[$];

  int edge_n = 0;
  int e0 = 0;
  always @(posedge clk) edge_n++;

  int issues, xfers, dones, lasts, first_en, first_valid, done_rel, last_xfer_num, rel;
  int last_addr;
  int xfer_rel[$];
  int addr_log[$];
  logic stall_prev = 1'b0, abort_prev = 1'b0, last_prev;
  logic [31:0] ts_prev, data_prev;
  exp_t ecur;

  // Single compare process
  always @(negedge clk) begin
    if (rst_n) begin
      rel = edge_n - e0 + 1;
      if (bus.BramEn_SO) begin
        chk("bram_addr", 64'(bus.BramAddr_SO), 64'(issues * 8));
        if (first_en < 0) first_en = rel;
        addr_log.push_back(int'(bus.BramAddr_SO));
        last_addr = int'(bus.BramAddr_SO);
        issues++;
      end
      if (bus.Valid_SO && first_valid < 0) first_valid = rel;
      if (stall_prev && !abort_prev) begin
        chk("stall_valid_held", 64'(bus.Valid_SO), 1);
        chk("stall_ts_stable", 64'(bus.Timestamp_DO), 64'(ts_prev));
        chk("stall_data_stable", 64'(bus.LogData_DO), 64'(data_prev));
        chk("stall_last_stable", 64'(bus.Last_SO), 64'(last_prev));
      end
      if (bus.Valid_SO && bus.Ready_SI) begin
        xfers++;
        xfer_rel.push_back(rel);
        chk("xfer_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          ecur = exp_q.pop_front();
          chk("xfer_ts", 64'(bus.Timestamp_DO), 64'(ecur.ts));
          chk("xfer_data", 64'(bus.LogData_DO), 64'(ecur.data));
          chk("xfer_last", 64'(bus.Last_SO), 64'(ecur.last));
        end
        if (bus.Last_SO) begin lasts++; last_xfer_num = xfers; end
      end
      if (bus.Busy_SO) chk("occupancy_le_2", 64'((issues - xfers) <= 2), 1);
      if (bus.Done_SO) begin
        dones++;
        done_rel = rel;
        chk("done_model_empty", 64'(exp_q.size()), 0);
      end
      stall_prev = bus.Valid_SO && !bus.Ready_SI;
      abort_prev = bus.Abort_SI;
      ts_prev    = bus.Timestamp_DO;
      data_prev  = bus.LogData_DO;
      last_prev  = bus.Last_SO;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Expected stream: entries 0..min(n,NENT)-1, cut at the first cleared entry when stop-on-empty is built in.
  task automatic start_drain(input int n);
    int k;
    @(posedge clk); #1;
    k = (n > NENT) ? NENT : n;
    exp_q.delete();
    for (int i = 0; i < k; i++) begin
      exp_t e;
`ifdef BRAM_LOG_READER_STOP_ON_EMPTY_EN
      if (mem[i][31:0] == 32'd0) break;
`endif
      e.ts   = mem[i][31:0];
      e.data = mem[i][63:32];
      e.last = (i == k - 1);
      exp_q.push_back(e);
    end
    issues = 0; xfers = 0; dones = 0; lasts = 0;
    first_en = -1; first_valid = -1; done_rel = -1; last_xfer_num = -1; last_addr = -1;
    xfer_rel.delete();
    addr_log.delete();
    bus.Start_SI      = 1'b1;
    bus.NumEntries_DI = 11'(n);
    @(posedge clk); #1;
    e0 = edge_n;
    bus.Start_SI = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (dones == 0 && k < budget) begin @(negedge clk); k++; end
    chk("done_within_budget", 64'(dones != 0), 1);
    repeat (4) @(negedge clk);
    chk("done_single_pulse", 64'(dones), 1);
    chk("model_drained", 64'(exp_q.size()), 0);
    chk("idle_after_done", 64'(bus.Busy_SO), 0);
    $display("drain: issues=%0d xfers=%0d lasts=%0d done_cycle=%0d", issues, xfers, lasts, done_rel);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(bus.Valid_SO), 0);
    chk({tag, "_bram_en"}, 64'(bus.BramEn_SO), 0);
    chk({tag, "_bram_addr"}, 64'(bus.BramAddr_SO), 0);
    chk({tag, "_busy"}, 64'(bus.Busy_SO), 0);
    chk({tag, "_done"}, 64'(bus.Done_SO), 0);
    chk({tag, "_last"}, 64'(bus.Last_SO), 0);
    chk({tag, "_ts"}, 64'(bus.Timestamp_DO), 0);
    chk({tag, "_data"}, 64'(bus.LogData_DO), 0);
  endtask

  initial begin
    for (int i = 0; i < NENT; i++) mem[i] = {32'($urandom), 32'($urandom) | 32'd1};
    bus.Start_SI = 1'b0; bus.Abort_SI = 1'b0; bus.NumEntries_DI = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic drain of 4 with Ready held high
    ready_mode = 1;
    start_drain(4);
    wait_done(100);
    chk("t1_issues", 64'(issues), 4);
    chk("t1_xfers", 64'(xfers), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 64'((i < addr_log.size()) ? addr_log[i] : -1), 64'(i * 8));
      chk("t1_xfer_cycle", 64'((i < xfer_rel.size()) ? xfer_rel[i] : -1), 64'(i + 3));
    end
    chk("t1_first_en_cycle", 64'(first_en), 1);
    chk("t1_first_valid_cycle", 64'(first_valid), 3);
    chk("t1_last_on_4th", 64'(last_xfer_num), 4);
    chk("t1_done_cycle", 64'(done_rel), 7);

    // 1-in-3 Ready, with an ignored Start mid-drain
    ready_mode = 2;
    start_drain(16);
    repeat (8) @(posedge clk);
    chk("t2_busy_at_restart", 64'(bus.Busy_SO), 1);
    #1 bus.Start_SI = 1'b1; bus.NumEntries_DI = 11'd3;
    @(posedge clk); #1 bus.Start_SI = 1'b0;
    wait_done(500);
    chk("t2_xfers", 64'(xfers), 16);
    chk("t2_lasts", 64'(lasts), 1);

    // Zero-length drain
    ready_mode = 1;
    start_drain(0);
    wait_done(20);
    chk("t3_issues", 64'(issues), 0);
    chk("t3_xfers", 64'(xfers), 0);
    chk("t3_done_cycle", 64'(done_rel), 1);

    // Oversized count is clamped to the log depth
    ready_mode = 3;
    start_drain(NENT + 5);
    wait_done(20000);
    chk("t4_xfers", 64'(xfers), 64'(NENT));
    chk("t4_issues", 64'(issues), 64'(NENT));
    chk("t4_last_addr", 64'(last_addr), 64'((NENT - 1) * 8));
    chk("t4_lasts", 64'(lasts), 1);

    // Abort after the 3rd transfer with two entries buffered
    ready_mode = 1;
    start_drain(16);
    ready_mode = 0;
    repeat (5) @(posedge clk);
    #1 bus.Ready_SI = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_xfers_before_abort", 64'(xfers), 3);
    chk("t5_outstanding", 64'(issues - xfers), 2);
    chk("t5_valid_before_abort", 64'(bus.Valid_SO), 1);
    @(posedge clk); #1 bus.Abort_SI = 1'b1; bus.Start_SI = 1'b1;
    @(posedge clk); #1 bus.Abort_SI = 1'b0; bus.Start_SI = 1'b0;
    @(negedge clk);
    chk("t5_valid_after_abort", 64'(bus.Valid_SO), 0);
    chk("t5_busy_after_abort", 64'(bus.Busy_SO), 0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    chk("t5_no_done", 64'(dones), 0);
    chk("t5_still_idle", 64'(bus.Busy_SO), 0);
    ready_mode = 1;
    start_drain(4);
    wait_done(100);
    chk("t5_restart_addr0", 64'((addr_log.size() > 0) ? addr_log[0] : -1), 0);
    chk("t5_restart_xfers", 64'(xfers), 4);

    // Cleared entry at index 6
    mem[6][31:0] = 32'd0;
    start_drain(12);
    wait_done(200);
`ifdef BRAM_LOG_READER_STOP_ON_EMPTY_EN
    chk("t6_xfers", 64'(xfers), 6);
    chk("t6_lasts", 64'(lasts), 0);
`else
    chk("t6_xfers", 64'(xfers), 12);
    chk("t6_lasts", 64'(lasts), 1);
`endif
    mem[6][31:0] = 32'h1234_5679;

    // Random lengths and backpressure
    ready_mode = 3;
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(0, 40);
      start_drain(n);
      wait_done(2000);
      chk("t7_xfers", 64'(xfers), 64'(n));
    end

    // Asynchronous reset mid-read
    ready_mode = 3;
    start_drain(64);
    repeat (10) @(posedge clk);
    chk("t8_busy_before_reset", 64'(bus.Busy_SO), 1);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    ready_mode = 1;
    start_drain(5);
    wait_done(100);
    chk("t8_recover_xfers", 64'(xfers), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
